// File: rtl/sha_seq_pkg.sv
// Shared types and constants for the SHA-1 block sequencer.
// Also carries the SHA-1 initial hash values, with H0 in the low word.
package sha_seq_pkg;

    localparam int BLOCK_W_DEF  = 512;
    localparam int DIGEST_W_DEF = 160;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;
    localparam logic [159:0] SHA1_IV = {SHA1_H4, SHA1_H3, SHA1_H2, SHA1_H1, SHA1_H0};

endpackage

// File: rtl/sha_seq_watchdog.sv
// Wait-cycle counter for the sequencer's core_done timeout.
// Expire fires in the WAIT cycle whose increment would bring the count to TIMEOUT-1.
module sha_seq_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_r;

    assign expire = en && (cnt_r == CW'(TIMEOUT - 2));

    // Cycle counter: cleared before WAIT, counts while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && !expire) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/sha_block_sequencer.sv
// Sequences the SHA-1 core over multi-block messages and latches the final digest.
// Optional core_done timeout: define SHA_SEQ_TIMEOUT_EN.
module sha_block_sequencer
    import sha_seq_pkg::*;
#(
    parameter int BLOCK_W  = BLOCK_W_DEF,
    parameter int DIGEST_W = DIGEST_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TIMEOUT  = 1024
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [BLOCK_W-1:0]  blk_data,
    input  logic                blk_empty,
    input  logic                blk_last,
    input  logic                abort,
    output logic                blk_rd,
    output logic [BLOCK_W-1:0]  core_block,
    output logic                core_start,
    output logic                core_init,
    input  logic                core_done,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy,
    output logic [CNT_W-1:0]    blk_count,
    output logic                err
);

    seq_state_t          state_r, next_state_s;
    logic                first_flag_r, last_flag_r;
    logic [BLOCK_W-1:0]  core_block_r;
    logic                core_init_r;
    logic [DIGEST_W-1:0] digest_r;
    logic                digest_valid_r;
    logic [CNT_W-1:0]    blk_count_r;
    logic                busy_r;
    logic                blk_rd_s, core_start_s, done_s, timeout_s, first_start_s;

`ifdef SHA_SEQ_TIMEOUT_EN
    logic wd_expire_s;
    logic err_r;

    sha_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (sys_clk),
        .rst_n  (sys_rst),
        .clr    (state_r == START),
        .en     (state_r == WAIT),
        .expire (wd_expire_s)
    );

    // core_done arriving on the expiry cycle still counts as a completion
    assign timeout_s = wd_expire_s && !core_done && !abort;

    // Sticky timeout flag, cleared only by a first-block launch
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            err_r <= 1'b0;
        end else if (first_start_s) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    next_state_s = blk_empty ? IDLE : START;
                START:   next_state_s = WAIT;
                WAIT:    next_state_s = (core_done || timeout_s) ? IDLE : WAIT;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Strobes decoded from the current state
    always_comb begin
        blk_rd_s      = 1'b0;
        core_start_s  = 1'b0;
        done_s        = 1'b0;
        if (abort) begin
            blk_rd_s     = 1'b0;
        end else begin
            case (state_r)
                IDLE:    blk_rd_s     = !blk_empty;
                START:   core_start_s = 1'b1;
                WAIT:    done_s       = core_done;
                default: blk_rd_s     = 1'b0;
            endcase
        end
        first_start_s = core_start_s && first_flag_r;
    end

    // Fetch capture and message-boundary flags
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            core_block_r <= '0;
            core_init_r  <= 1'b0;
            last_flag_r  <= 1'b0;
            first_flag_r <= 1'b1;
        end else begin
            if (blk_rd_s) begin
                core_block_r <= blk_data;
                core_init_r  <= first_flag_r;
                last_flag_r  <= blk_last;
            end else begin
                core_block_r <= core_block_r;
                core_init_r  <= core_init_r;
                last_flag_r  <= last_flag_r;
            end
            if (abort || timeout_s) begin
                first_flag_r <= 1'b1;
            end else if (done_s) begin
                first_flag_r <= last_flag_r;
            end else begin
                first_flag_r <= first_flag_r;
            end
        end
    end

    // Digest, valid flag, block counter and busy
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            digest_r       <= '0;
            digest_valid_r <= 1'b0;
            blk_count_r    <= '0;
            busy_r         <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            if (first_start_s) begin
                blk_count_r    <= '0;
                digest_valid_r <= 1'b0;
                digest_r       <= digest_r;
            end else if (done_s) begin
                blk_count_r    <= blk_count_r + CNT_W'(1);
                digest_valid_r <= digest_valid_r | last_flag_r;
                digest_r       <= last_flag_r ? core_digest : digest_r;
            end else begin
                blk_count_r    <= blk_count_r;
                digest_valid_r <= digest_valid_r;
                digest_r       <= digest_r;
            end
        end
    end

    assign blk_rd       = blk_rd_s;
    assign core_start   = core_start_s;
    assign core_block   = core_block_r;
    assign core_init    = core_init_r;
    assign digest       = digest_r;
    assign digest_valid = digest_valid_r;
    assign blk_count    = blk_count_r;
    assign busy         = busy_r;

endmodule
